// File: rtl/multiplier_datapath_pkg.sv
// Shared multiplier controller state encoding and datapath constants.
package multiplier_datapath_pkg;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_COMPUTE_PROD0 = 3'd1,
        ST_COMPUTE_PROD1 = 3'd2,
        ST_COMPUTE_PROD2 = 3'd3,
        ST_COMPUTE_PROD3 = 3'd4,
        ST_END           = 3'd5
    } multiplier_states_t;

    localparam int unsigned MULT_PP_COUNT = 4;

endpackage

// File: rtl/multiplier_datapath_half_pp.sv
// Combinational H x H -> 2H unsigned multiplier for one partial product.
module mult_half_pp #(
    parameter int unsigned H = 4
) (
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-1:0] p_o
);

    always_comb begin
        p_o = (2*H)'(a_i) * (2*H)'(b_i);
    end

endmodule

// File: rtl/multiplier_datapath.sv
// Multiplier datapath: captures operands, accumulates four half-width partial products.
// Optional macro DONE_PULSE_EN: done_o pulses once on entry to ST_END instead of a level.
module multiplier_datapath
    import multiplier_datapath_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           strt_cmpt_i,
    input  logic [2:0]     state_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] product_o,
    output logic           done_o,
    output logic           busy_o
);

    localparam int unsigned H = W / 2;

    multiplier_states_t state;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [2*W-1:0]     res_q, res_d;
    logic [H-1:0]       a_half, b_half;
    logic [W-1:0]       pp;
    logic [2*W-1:0]     pp_wide;
    logic [2*W-1:0]     pp_shift;
    logic [2*W-1:0]     sum;

    assign state = multiplier_states_t'(state_i);

    // Operand halves chosen by the controller step; unused steps feed zeros.
    always_comb begin
        a_half = '0;
        b_half = '0;
        case (state)
            ST_COMPUTE_PROD0: begin a_half = a_q[H-1:0]; b_half = b_q[H-1:0]; end
            ST_COMPUTE_PROD1: begin a_half = a_q[W-1:H]; b_half = b_q[H-1:0]; end
            ST_COMPUTE_PROD2: begin a_half = a_q[H-1:0]; b_half = b_q[W-1:H]; end
            ST_COMPUTE_PROD3: begin a_half = a_q[W-1:H]; b_half = b_q[W-1:H]; end
            default: ;
        endcase
    end

    mult_half_pp #(.H(H)) u_half_pp (
        .a_i (a_half),
        .b_i (b_half),
        .p_o (pp)
    );

    always_comb begin
        pp_wide  = {{W{1'b0}}, pp};
        pp_shift = pp_wide;
        case (state)
            ST_COMPUTE_PROD1,
            ST_COMPUTE_PROD2: pp_shift = pp_wide << H;
            ST_COMPUTE_PROD3: pp_shift = pp_wide << W;
            default:          pp_shift = pp_wide;
        endcase
        sum = acc_q + pp_shift;
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        res_d = res_q;
        case (state)
            ST_IDLE: begin
                if (strt_cmpt_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    acc_d = '0;
                end
            end
            ST_COMPUTE_PROD0,
            ST_COMPUTE_PROD1,
            ST_COMPUTE_PROD2: acc_d = sum;
            ST_COMPUTE_PROD3: begin
                acc_d = sum;
                res_d = sum;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign product_o = res_q;

    // Status outputs are decoded from state_i, so reset must mask them explicitly.
    always_comb begin
        busy_o = 1'b0;
        if (!rst_i) begin
            case (state)
                ST_COMPUTE_PROD0, ST_COMPUTE_PROD1,
                ST_COMPUTE_PROD2, ST_COMPUTE_PROD3: busy_o = 1'b1;
                default:                            busy_o = 1'b0;
            endcase
        end
    end

`ifdef DONE_PULSE_EN
    multiplier_states_t prev_state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_state_q <= ST_IDLE;
        end else begin
            prev_state_q <= state;
        end
    end

    assign done_o = !rst_i && (prev_state_q == ST_COMPUTE_PROD3) && (state == ST_END);
`else
    assign done_o = !rst_i && (state == ST_END);
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath: vector table, directed corner cases, random runs.
module tb_multiplier_datapath;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst;
    logic           strt;
    logic [2:0]     state;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    logic           done;
    logic           busy;

    int total;
    int bad;

    multiplier_datapath #(.W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .strt_cmpt_i (strt),
        .state_i     (state),
        .a_i         (a),
        .b_i         (b),
        .product_o   (product),
        .done_o      (done),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One full controller sequence IDLE(start) -> PROD0..3 -> END -> IDLE.
    // corrupt: scramble operand inputs during PROD1..PROD3.
    task automatic run_mult(input logic [W-1:0] av, input logic [W-1:0] bv, input bit corrupt);
        logic [2*W-1:0] exp;
        exp   = (2*W)'(av) * (2*W)'(bv);
        state = 3'd0; strt = 1'b1; a = av; b = bv;
        sample();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        for (int s = 1; s <= 4; s++) begin
            next_cycle();
            state = 3'(s); strt = 1'b0;
            if (corrupt && s >= 2) begin
                a = '1; b = '1;
            end else begin
                a = $urandom_range(255, 0); b = $urandom_range(255, 0);
            end
            sample();
            check("prod_busy", 32'(busy), 32'd1);
            check("prod_done", 32'(done), 32'd0);
        end
        next_cycle();
        state = 3'd5;
        sample();
        check("end_product", 32'(product), 32'(exp));
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        next_cycle();
        state = 3'd0; strt = 1'b0;
        sample();
        check("idle_hold_product", 32'(product), 32'(exp));
        check("idle_hold_done", 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] exp;
        total = 0;
        bad   = 0;

        vecs[0] = '{a: 8'h12, b: 8'h34, p: 16'h03A8};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
        vecs[2] = '{a: 8'hA5, b: 8'h3C, p: 16'h26AC};
        vecs[3] = '{a: 8'h00, b: 8'hC7, p: 16'h0000};
        vecs[4] = '{a: 8'h0F, b: 8'h0F, p: 16'h00E1};

        // Reset state, with busy/done-producing state codes forced on state_i.
        rst = 1'b1; strt = 1'b0; state = 3'd1; a = '0; b = '0;
        #12;
        check("rst_product", 32'(product), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        state = 3'd5;
        #1;
        check("rst_done", 32'(done), 32'd0);
        state = 3'd0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Vector table; expected products come from the table itself.
        for (int i = 0; i < 5; i++) begin
            run_mult(vecs[i].a, vecs[i].b, 1'b0);
            check("table_product", 32'(product), 32'(vecs[i].p));
        end

        // Operands changed after capture must not affect the result.
        run_mult(8'h12, 8'h34, 1'b1);

        // Asynchronous reset in the middle of PROD2.
        next_cycle();
        state = 3'd0; strt = 1'b1; a = 8'h77; b = 8'h99;
        for (int s = 1; s <= 3; s++) begin
            next_cycle();
            state = 3'(s); strt = 1'b0;
        end
        #2;
        check("pre_rst_product", 32'(product), 32'h03A8);
        rst = 1'b1;
        #1;
        check("async_rst_product", 32'(product), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        next_cycle();
        state = 3'd0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        run_mult(8'h0F, 8'h0F, 1'b0);

        // Start held high into ST_END for three cycles, then illegal states.
        next_cycle();
        state = 3'd0; strt = 1'b1; a = 8'h12; b = 8'h34;
        for (int s = 1; s <= 4; s++) begin
            next_cycle();
            state = 3'(s);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            state = 3'd5;
            sample();
            check("hold_end_product", 32'(product), 32'h03A8);
`ifdef DONE_PULSE_EN
            check("hold_end_done", 32'(done), (k == 0) ? 32'd1 : 32'd0);
`else
            check("hold_end_done", 32'(done), 32'd1);
`endif
        end
        for (int k = 6; k <= 7; k++) begin
            next_cycle();
            state = 3'(k); a = 8'hFF; b = 8'hFF;
            sample();
            check("illegal_done", 32'(done), 32'd0);
            check("illegal_busy", 32'(busy), 32'd0);
            check("illegal_product", 32'(product), 32'h03A8);
        end
        next_cycle();
        state = 3'd0; strt = 1'b0;
        sample();
        check("after_illegal_product", 32'(product), 32'h03A8);

        // Randomized runs against plain integer multiplication.
        for (int i = 0; i < 25; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            exp = (2*W)'(ra) * (2*W)'(rb);
            next_cycle();
            run_mult(ra, rb, i[0]);
            check("rand_product", 32'(product), 32'(exp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier_datapath.md
Name: multiplier_datapath

Overview:
Datapath stage directly downstream of the multiplier controller FSM. It consumes the controller's 3-bit state and the same start command, and latches two unsigned W-bit operands. It accumulates four half-width partial products, one per ST_COMPUTE_PROD0..3 state, and presents the 2W-bit product with a done flag while the controller sits in ST_END.

Parameters:
W, 8, operand width in bits; must be even and >= 4; H = W/2 is the half width.

Ports:
clk_i  input  1  system clock, rising-edge.
rst_i  input  1  asynchronous, active-high reset.
strt_cmpt_i  input  1  start command; same signal that drives the controller.
state_i  input  3  controller state, encoded per the shared multiplier_states_t.
a_i  input  W  operand A, unsigned.
b_i  input  W  operand B, unsigned.
product_o  output  2W  registered product A*B.
done_o  output  1  product valid flag.
busy_o  output  1  high while state_i is any ST_COMPUTE_PROD* state.

Behaviour:
- Reset (rst_i=1, asynchronous, any time including mid-computation):
  - Clears the operand registers a_q and b_q, accumulator acc (2W bits) and result register res.
  - product_o=0, done_o=0, busy_o=0.
  - There is no resume: the next computation requires a new start from ST_IDLE.
- State encoding (fixed): ST_IDLE=0, ST_COMPUTE_PROD0=1, PROD1=2, PROD2=3, PROD3=4, ST_END=5; values 6 and 7 are illegal.
- Capture, cycle c: state_i==ST_IDLE and strt_cmpt_i==1.
  - At the closing edge: a_q<=a_i, b_q<=b_i, acc<=0.
  - No other state captures; a_i/b_i changes after cycle c are ignored.
- Partial products from the half-width sub-multiplier. Each is zero-extended to 2W before shifting:
  - PROD0: a_q[H-1:0]*b_q[H-1:0].
  - PROD1: (a_q[W-1:H]*b_q[H-1:0]) << H.
  - PROD2: (a_q[H-1:0]*b_q[W-1:H]) << H.
  - PROD3: (a_q[W-1:H]*b_q[W-1:H]) << W.
- Accumulation:
  - In PROD0..PROD2: acc <= acc + pp at the closing edge.
  - In PROD3: acc <= acc + pp and res <= acc + pp at the same edge.
  - The sum never exceeds 2W bits; no overflow handling is required.
- Latency: start sampled in cycle c; product_o valid from cycle c+5, the first ST_END cycle.
- product_o = res. It holds its value through ST_END and ST_IDLE and changes only at the next PROD3 edge or on reset.
- done_o (default build) = (state_i==ST_END), combinational level; it stays high while the controller holds ST_END with start asserted.
- busy_o = state_i in {1,2,3,4}, combinational.
- Illegal state_i (6, 7): all registers hold, done_o=0, busy_o=0.
- Start held high through ST_END back into ST_IDLE re-captures operands on that IDLE cycle; this is the intended behaviour.

Optional Feature:
DONE_PULSE_EN
- Defined: done_o is registered and pulses high for exactly one cycle, the first ST_END cycle.
  - Implemented by registering the previous state and pulsing on the PROD3->END transition.
  - The register resets to 0; no further pulse occurs while the controller stays in ST_END.
- Undefined: done_o is the combinational ST_END level described above.

Decomposition:
- The shared states definitions file/package holds:
  - multiplier_states_t (3-bit enum, encoding above);
  - a MULT_PP_COUNT=4 constant.
- This block imports it; no local copy of the state encoding is allowed.
- One natural sub-module: mult_half_pp, a purely combinational H x H -> 2H unsigned multiplier.
  - Operand halves are selected by state_i in the parent.
  - Shift and accumulate stay in the parent.

Test Plan:
1. W=8, a=0x12, b=0x34, one start pulse; controller drives states 0,1,2,3,4,5 -> product_o=0x03A8 and done_o=1 at cycle c+5; product_o still 0x03A8 after return to IDLE.
2. a=0xFF, b=0xFF -> product_o=0xFE01; then a=0xA5, b=0x3C -> 0x26AC (partial products 0x3C, 0x780, 0xF0, 0x1E00).
3. a=0x00, b=0xC7 -> product_o=0x0000, done_o asserted in ST_END; busy_o high for exactly 4 cycles.
4. Change a_i/b_i to 0xFF during PROD1..PROD3 of a 0x12*0x34 run -> result unaffected, 0x03A8.
5. Assert rst_i asynchronously mid-PROD2 -> product_o, done_o and busy_o go to 0 immediately; a fresh run with a=0x0F, b=0x0F yields 0x00E1.
6. Hold start high into ST_END for 3 cycles -> done_o high 3 cycles (level build) or 1 cycle (DONE_PULSE_EN); force state_i=6 -> done_o=0, product_o unchanged.
